vga_timing_gen: RTL

Parametrised VGA timing generator that replaces the fixed 640x480 controller in the display path. It counts pixels and lines from generics for any mode, drives lookahead pixel coordinates to the pixel generator (background, sprites, health bars, menu), and delays sync and blank to match a configurable pixel-generator latency. The final colour, sync and blank outputs are registered and pixel-aligned for the video DAC and monitor.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing types and the 640x480@60 default mode for the display path.
package vga_pkg;

    // 640x480@60 defaults, horizontal axis (pixels)
    localparam int unsigned VGA_H_ACTIVE = 32'd640;
    localparam int unsigned VGA_H_FP     = 32'd16;
    localparam int unsigned VGA_H_SYNC   = 32'd96;
    localparam int unsigned VGA_H_BP     = 32'd48;

    // 640x480@60 defaults, vertical axis (lines)
    localparam int unsigned VGA_V_ACTIVE = 32'd480;
    localparam int unsigned VGA_V_FP     = 32'd10;
    localparam int unsigned VGA_V_SYNC   = 32'd2;
    localparam int unsigned VGA_V_BP     = 32'd33;

    // Timing of one axis: visible span followed by front porch, sync pulse, back porch.
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_mode_t;

    // Full period of one axis (pixels per line or lines per frame).
    function automatic int unsigned axis_total(input axis_mode_t mode);
        return 32'(mode.active) + 32'(mode.fp) + 32'(mode.sync) + 32'(mode.bp);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with a parameterised reset value so
// that sync bits flush to their deasserted level. DEPTH=0 is a plain wire.
module vga_delay_line #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         vgaclk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset are not needed when there is no storage.
            logic unused_s;
            assign unused_s = vgaclk ^ reset;
            assign dout     = din;
        end else begin : g_shift
            logic [W-1:0] stage_r [DEPTH];

            // Shift the bundle one stage per pixel clock; reset flushes every stage.
            always_ff @(posedge vgaclk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_r[i] <= RST_VAL;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator. Counters give lookahead x/y to
// the pixel generator; active/sync are delayed by PIX_LAT and registered together
// with the returning colour so everything leaves the block pixel-aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned PIX_LAT   = 2,
    parameter int unsigned COORD_W   = 10
) (
    input  logic               vgaclk,
    input  logic               reset,
    input  logic [7:0]         r_int,
    input  logic [7:0]         g_int,
    input  logic [7:0]         b_int,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt,
    output logic               hsync,
    output logic               vsync,
    output logic               sync_b,
    output logic               blank_b,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b
);

    localparam axis_mode_t H_MODE = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                      sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam axis_mode_t V_MODE = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                                      sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int unsigned H_TOTAL = axis_total(H_MODE);
    localparam int unsigned V_TOTAL = axis_total(V_MODE);

    // Sync windows compared in 32 bits so an end at 2**COORD_W cannot overflow.
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 32'd1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 32'd1);

    localparam logic [2:0] DLY_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

    generate
        if (64'(H_TOTAL) > (64'd1 << COORD_W)) begin : g_err_h
            $error("vga_timing_gen: COORD_W too small for H_TOTAL-1");
        end
        if (64'(V_TOTAL) > (64'd1 << COORD_W)) begin : g_err_v
            $error("vga_timing_gen: COORD_W too small for V_TOTAL-1");
        end
        if (PIX_LAT > 7) begin : g_err_lat
            $error("vga_timing_gen: PIX_LAT must be 0..7");
        end
    endgenerate

    logic [COORD_W-1:0] hcnt_r;
    logic [COORD_W-1:0] vcnt_r;
    logic [7:0]         frame_cnt_r;
    logic               h_wrap_s;
    logic               v_wrap_s;
    logic               active_s;
    logic               hsync_lvl_s;
    logic               vsync_lvl_s;
    logic [2:0]         dly_out_s;
    logic               hsync_r;
    logic               vsync_r;
    logic               sync_b_r;
    logic               blank_b_r;
    logic [7:0]         r_r;
    logic [7:0]         g_r;
    logic [7:0]         b_r;

    // Wrap detection and undelayed decode of visible area and sync levels.
    always_comb begin
        h_wrap_s    = (hcnt_r == H_LAST);
        v_wrap_s    = (vcnt_r == V_LAST);
        active_s    = (32'(hcnt_r) < H_ACTIVE) && (32'(vcnt_r) < V_ACTIVE);
        hsync_lvl_s = ((32'(hcnt_r) >= HS_START) && (32'(hcnt_r) < HS_END)) ?
                      HSYNC_POL : ~HSYNC_POL;
        vsync_lvl_s = ((32'(vcnt_r) >= VS_START) && (32'(vcnt_r) < VS_END)) ?
                      VSYNC_POL : ~VSYNC_POL;
    end

    // Pixel, line and frame counters; at the last pixel of the frame all roll on one edge.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hcnt_r      <= '0;
            vcnt_r      <= '0;
            frame_cnt_r <= 8'd0;
        end else if (h_wrap_s) begin
            hcnt_r <= '0;
            if (v_wrap_s) begin
                vcnt_r      <= '0;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                vcnt_r <= vcnt_r + COORD_W'(1);
            end
        end else begin
            hcnt_r <= hcnt_r + COORD_W'(1);
        end
    end

    vga_delay_line #(
        .DEPTH   (PIX_LAT),
        .W       (3),
        .RST_VAL (DLY_RST)
    ) u_dly (
        .vgaclk (vgaclk),
        .reset  (reset),
        .din    ({active_s, hsync_lvl_s, vsync_lvl_s}),
        .dout   (dly_out_s)
    );

    // Output stage: sync, blank and colour leave together; colour outside the window is dropped.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hsync_r   <= ~HSYNC_POL;
            vsync_r   <= ~VSYNC_POL;
            sync_b_r  <= (~HSYNC_POL) | (~VSYNC_POL);
            blank_b_r <= 1'b0;
            r_r       <= 8'h00;
            g_r       <= 8'h00;
            b_r       <= 8'h00;
        end else begin
            hsync_r   <= dly_out_s[1];
            vsync_r   <= dly_out_s[0];
            sync_b_r  <= dly_out_s[1] | dly_out_s[0];
            blank_b_r <= dly_out_s[2];
            if (dly_out_s[2]) begin
                r_r <= r_int;
                g_r <= g_int;
                b_r <= b_int;
            end else begin
                r_r <= 8'h00;
                g_r <= 8'h00;
                b_r <= 8'h00;
            end
        end
    end

    assign x           = hcnt_r;
    assign y           = vcnt_r;
    assign active      = active_s;
    assign line_start  = (hcnt_r == '0);
    assign frame_start = (hcnt_r == '0) && (vcnt_r == '0);
    assign frame_cnt   = frame_cnt_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign sync_b      = sync_b_r;
    assign blank_b     = blank_b_r;
    assign r           = r_r;
    assign g           = g_r;
    assign b           = b_r;

endmodule
